// File: rtl/i2s_tdm_rx.sv
// I2S / TDM serial audio receiver: oversampled bclk/lrck/data, slot deserialiser, AXI-stream output FIFO.
// Optional dropped-word counter port o_ovf_cnt is built when I2S_TDM_RX_OVF_CNT_EN is defined.
module i2s_tdm_rx #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              mclki,
  input  logic              rst,
  input  logic              bclki,
  input  logic              lrcki,
  input  logic              datai,
  input  logic              i_enable,
  input  logic [2:0]        i_tdm_num,
  input  logic              i_word_width,
  input  logic [1:0]        i_valid_word_width,
  input  logic              i_lrck_polarity,
  input  logic              i_lrck_alignment,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [3:0]        m_axis_tid,
  output logic              m_axis_tlast,
  output logic              o_overflow,
  output logic              o_frame_err
`ifdef I2S_TDM_RX_OVF_CNT_EN
  ,
  output logic [15:0]       o_ovf_cnt
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_W + 5;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN} state_t;

  // ---------------------------------------------------------------- synchronisers
  logic [2:0] sync_q [SYNC_STAGES];   // {bclk, lrck, data}
  logic       bclk_s, lrck_s, data_s;
  logic       bclk_prev_q, lrck_prev_q, fs_dly_q;
  logic       bclk_rise, lrck_smp, frame_start, sof;

  always_ff @(posedge mclki) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bclki, lrcki, datai};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bclk_s      = sync_q[SYNC_STAGES-1][2];
  assign lrck_s      = sync_q[SYNC_STAGES-1][1];
  assign data_s      = sync_q[SYNC_STAGES-1][0];
  assign bclk_rise   = bclk_s & ~bclk_prev_q;
  assign lrck_smp    = lrck_s ^ i_lrck_polarity;
  assign frame_start = bclk_rise & lrck_smp & ~lrck_prev_q;
  // In I2S mode slot 0's MSB arrives one bclk after the frame edge.
  assign sof         = bclk_rise & (i_lrck_alignment ? frame_start : fs_dly_q);

  always_ff @(posedge mclki) begin
    if (rst) begin
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      fs_dly_q    <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
      if (bclk_rise) begin
        lrck_prev_q <= lrck_smp;
        fs_dly_q    <= frame_start;
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t state_q, state_d;
  logic   capture, in_run;

  always_ff @(posedge mclki) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_WAIT;
      ST_WAIT: if (sof) state_d = ST_RUN;
      default: state_d = state_q;
    endcase
    if (!i_enable) state_d = ST_IDLE;
  end

  always_comb begin
    capture = 1'b0;
    in_run  = 1'b0;
    case (state_q)
      ST_WAIT: capture = sof;
      ST_RUN: begin
        capture = bclk_rise;
        in_run  = 1'b1;
      end
      default: ;
    endcase
    if (!i_enable) begin
      capture = 1'b0;
      in_run  = 1'b0;
    end
  end

  // ---------------------------------------------------------------- deserialiser
  logic [4:0]  bit_cnt_q, bit_cnt_d, eff_bit, last_bit;
  logic [3:0]  slot_cnt_q, slot_cnt_d, eff_slot, last_slot;
  logic [31:0] shreg_q, shreg_d, aligned, valid_mask;
  logic        slot_done, frame_err_d;
  logic [ENTRY_W-1:0] push_entry;

  assign last_bit  = i_word_width ? 5'd31 : 5'd15;
  assign last_slot = {i_tdm_num, 1'b1};
  // A frame start always restarts at slot 0 / bit 0, dropping any partial word.
  assign eff_bit   = sof ? 5'd0 : bit_cnt_q;
  assign eff_slot  = sof ? 4'd0 : slot_cnt_q;
  assign shreg_d   = (eff_bit == 5'd0) ? {31'd0, data_s} : {shreg_q[30:0], data_s};
  assign slot_done = capture && (eff_bit == last_bit);
  assign aligned   = i_word_width ? shreg_d : {shreg_d[15:0], 16'd0};

  always_comb begin
    case (i_valid_word_width)
      2'd0:    valid_mask = 32'hFFFF_0000;
      2'd1:    valid_mask = 32'hFFFF_FF00;
      default: valid_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign push_entry  = {(eff_slot == last_slot), eff_slot,
                        DATA_W'(aligned & valid_mask) << (DATA_W - 32)};
  assign frame_err_d = in_run && sof && ((bit_cnt_q != 5'd0) || (slot_cnt_q != 4'd0));

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (capture) begin
      if (slot_done) begin
        bit_cnt_d  = 5'd0;
        slot_cnt_d = (eff_slot == last_slot) ? 4'd0 : eff_slot + 4'd1;
      end else begin
        bit_cnt_d  = eff_bit + 5'd1;
        slot_cnt_d = eff_slot;
      end
    end
  end

  always_ff @(posedge mclki) begin
    if (rst || !i_enable) begin
      bit_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      shreg_q     <= '0;
      o_frame_err <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      if (capture) shreg_q <= shreg_d;
      o_frame_err <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------- output FIFO
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               pop, full, wr_en, drop;
  logic [ENTRY_W-1:0] rd_entry;

  assign full  = (count_q == FULL_CNT);
  assign pop   = m_axis_tvalid && m_axis_tready;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = slot_done && (!full || pop);
  assign drop  = slot_done && full && !pop;

  always_ff @(posedge mclki) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge mclki) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_axis_tvalid = (count_q != '0);
  assign rd_entry      = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_axis_tlast  = rd_entry[ENTRY_W-1];
  assign m_axis_tid    = rd_entry[ENTRY_W-2 -: 4];
  assign m_axis_tdata  = rd_entry[DATA_W-1:0];

  always_ff @(posedge mclki) begin
    if (rst || !i_enable) o_overflow <= 1'b0;
    else if (drop)        o_overflow <= 1'b1;
  end

`ifdef I2S_TDM_RX_OVF_CNT_EN
  always_ff @(posedge mclki) begin
    if (rst)                                o_ovf_cnt <= '0;
    else if (drop && (o_ovf_cnt != 16'hFFFF)) o_ovf_cnt <= o_ovf_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/i2s_tdm_rx.md
I2S_TDM_RX -- requirements
Module: i2s_tdm_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32 (minimum 32), the width of m_axis_tdata.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16 (power of 2), the output FIFO depth in words.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, the synchroniser depth on bclki, lrcki and datai.
REQ-004 The block SHALL have ports, one per line:
- mclki  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- bclki  in  1  external bit clock.
- lrcki  in  1  external frame clock.
- datai  in  1  serial data.
- i_enable  in  1  receiver enable.
- i_tdm_num  in  3  slots per frame = 2*(i_tdm_num+1), giving 2..16.
- i_word_width  in  1  bclk per slot: 0=16, 1=32.
- i_valid_word_width  in  2  kept bits: 0=16, 1=24, 2/3=32.
- i_lrck_polarity  in  1  1 = frame start on falling lrck.
- i_lrck_alignment  in  1  0 = I2S (MSB one bclk after frame edge), 1 = left-justified.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tdata  out  DATA_W  word, MSB-aligned.
- m_axis_tid  out  4  slot index.
- m_axis_tlast  out  1  last slot of frame.
- o_overflow  out  1  sticky word-dropped flag.
- o_frame_err  out  1  one-cycle misalignment pulse.

Function
REQ-005 bclki, lrcki and datai SHALL each pass SYNC_STAGES flops; a bclk rising edge is synchronised-current=1 and previous=0; bclki frequency SHALL be at most mclki/4.
REQ-006 On each bclk rising edge the block SHALL sample the synchronised datai and lrcki (lrcki XOR i_lrck_polarity).
REQ-007 Frame start SHALL be a sampled lrck 0->1 transition between consecutive bclk rising edges.
REQ-008 FSM states SHALL be IDLE (i_enable=0), WAIT_FRAME (enabled, no frame start yet), RUN; IDLE->WAIT_FRAME on i_enable=1; WAIT_FRAME->RUN on frame start; any state->IDLE on i_enable=0.
REQ-009 In RUN, slot 0 MSB SHALL be the bit sampled at the frame-start edge when i_lrck_alignment=1, else the bit sampled at the next bclk edge.
REQ-010 A bit counter SHALL count 0..slot_bits-1 and a slot counter 0..slots-1, both wrapping to 0.
REQ-011 At slot completion the word SHALL be MSB-aligned in DATA_W, bits below the valid width zeroed, and pushed with tid=slot and tlast=(slot==slots-1).
REQ-012 A push SHALL reach m_axis_tvalid within 2 mclki cycles of the bclk-edge detection that sampled the LSB.
REQ-013 AXI-stream: a word transfers when tvalid&&tready; tdata, tid and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-014 FIFO full at push: the new word SHALL be dropped, FIFO contents kept, o_overflow set; o_overflow clears only on rst or i_enable=0.
REQ-015 Simultaneous push and pop on a full FIFO SHALL accept the push (no drop).
REQ-016 A frame start in RUN when the expected next-bit position is not slot 0 / bit 0 SHALL pulse o_frame_err for one cycle, discard the partial word, and realign counters with this edge as frame start.
REQ-017 i_enable=0 SHALL discard any partial word and clear counters; the FIFO SHALL keep draining.
REQ-018 Configuration inputs SHALL be changed only while i_enable=0; behaviour otherwise is undefined.

Reset
REQ-019 rst SHALL set FSM=IDLE, counters=0, FIFO empty, synchronisers=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tlast=0, o_overflow=0, o_frame_err=0.
REQ-020 rst asserted mid-frame SHALL drop all partial and buffered words, with no output transfer in the cycle after rst.

Configuration
REQ-021 With macro I2S_TDM_RX_OVF_CNT_EN defined, port o_ovf_cnt (out, 16) SHALL count dropped words, saturate at 0xFFFF, and clear only on rst; without the macro the port and counter SHALL be absent and all other behaviour unchanged.

Verification
REQ-022 Stereo I2S test: tdm_num=0, width=32, valid=24, alignment=0, L=0xA5A5A5, R=0x5A5A5A -> tdata 0xA5A5A500 tid0 tlast0, then 0x5A5A5A00 tid1 tlast1.
REQ-023 TDM16 test: tdm_num=7, width=32, valid=32, left-justified, polarity=1, slot n=0x1000_0000+n -> 16 words in order, tlast only on tid 15.
REQ-024 Backpressure test: tready=0 for 40 words with FIFO_DEPTH=16 -> 16 words kept, o_overflow=1, o_ovf_cnt=24 when macro defined, first 16 words intact after tready=1.
REQ-025 Misalignment test: early frame start in slot 1, bit 5, of a 4-slot frame -> one o_frame_err pulse, partial word dropped, next word tid0.
REQ-026 Disable test: i_enable=0 mid-slot with 2 words buffered -> those 2 words delivered, no partial word, FSM IDLE; re-enable waits for frame start.
